// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side constants: instruction address/word widths and default queue depth.
// Also provides the packed-entry width helper used by the fetch queue.
package fetch_queue_pkg;

    localparam int unsigned IM_ADDR_BIT = 10;
    localparam int unsigned INSTR_BIT   = 32;
    localparam int unsigned FQ_DEPTH    = 4;

    // One queue entry carries {pc, pc_4, instr}.
    function automatic int unsigned entry_width(input int unsigned addr_w,
                                                input int unsigned instr_w);
        return 2 * addr_w + instr_w;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo_core.sv
// Generic synchronous FIFO: reset-cleared storage, wrapping pointers, occupancy count.
// clear_i empties the queue (pointers/count) with priority over push/pop and leaves storage intact.
module fetch_queue_fifo_core #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state: clear wins; pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between PC/instruction memory and decode.
// Back-pressures the PC via pc_en; flush discards wrong-path entries on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned ADDR_W  = IM_ADDR_BIT,
    parameter  int unsigned INSTR_W = INSTR_BIT,
    parameter  int unsigned DEPTH   = FQ_DEPTH,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1,
    localparam int unsigned ENT_W   = entry_width(ADDR_W, INSTR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [ADDR_W-1:0]  in_pc_4,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               pc_en,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_4,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    input  logic               flush,
    output logic [CNT_W-1:0]   count
);

    logic             enq;
    logic             deq;
    logic             full;
    logic             empty;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

    // Readiness comes only from registered occupancy; no out_ready -> in_ready path.
    assign in_ready  = ~full;
    assign pc_en     = ~full;
    assign out_valid = ~empty;
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign wr_entry  = {in_pc, in_pc_4, in_instr};

    fetch_queue_fifo_core #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (flush),
        .push_i  (enq),
        .pop_i   (deq),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {out_pc, out_pc_4, out_instr} = rd_entry;

    a_no_enq_when_full : assert property (@(posedge clk) disable iff (rst)
        (count == CNT_W'(DEPTH)) |-> !enq);
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus random traffic vs. a queue model.
module tb_fetch_queue;

    localparam int unsigned AW = 10;
    localparam int unsigned IW = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [AW-1:0] in_pc;
    logic [AW-1:0] in_pc_4;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          pc_en;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_4;
    logic [IW-1:0] out_instr;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [IW-1:0] ins;
    } ent_t;

    ent_t exp_q[$];
    int   exp_cnt = 0;
    int   total   = 0;
    int   bad     = 0;

    fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_pc_4   (in_pc_4),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .pc_en     (pc_en),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_pc_4  (out_pc_4),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Fold the inputs that were live at the last rising edge into the reference model.
    task automatic account();
        bit acc;
        bit dq;
        acc = in_valid && (exp_cnt != D);
        dq  = (exp_cnt != 0) && out_ready;
        if (rst || flush) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (acc) exp_q.push_back('{pc: in_pc, pc4: in_pc_4, ins: in_instr});
            exp_cnt = exp_cnt + int'(acc) - int'(dq);
        end
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                         input bit ord, input bit fl);
        @(posedge clk);
        #2;
        account();
        in_valid  = v;
        in_pc     = pc;
        in_pc_4   = pc + AW'(1);
        in_instr  = ins;
        out_ready = ord;
        flush     = fl;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        repeat (D + 2) drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Mid-cycle asynchronous reset; effect checked before any clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        account();
        rst = 1'b1;
        idle_inputs();
        exp_q.delete();
        exp_cnt = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        @(posedge clk);
        #2;
        account();
        rst = 1'b0;
    endtask

    // Monitor: occupancy/handshake every cycle, head data on each consumed entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            chk("count", count, exp_cnt);
            chk("in_ready", in_ready, exp_cnt != D);
            chk("pc_en", pc_en, exp_cnt != D);
            chk("out_valid", out_valid, exp_cnt != 0);
            if (exp_cnt != 0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_pc_4", out_pc_4, e.pc4);
                    chk("out_instr", out_instr, e.ins);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        in_pc = '0;
        in_pc_4 = '0;
        in_instr = '0;
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        chk("init_count", count, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_instr", out_instr, 0);
        @(posedge clk);
        #2;
        account();
        rst = 1'b0;

        // Fill to full, then a fifth offer that must be refused.
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(32'h10 + i), IW'(32'hA0 + i), 1'b0, 1'b0);
        drive(1'b1, AW'(32'h14), IW'(32'hA4), 1'b0, 1'b0);
        drive(1'b1, AW'(32'h15), IW'(32'hA5), 1'b0, 1'b0);
        // Full plus dequeue: incoming refused this edge, accepted next.
        drive(1'b1, AW'(32'h30), IW'(32'hB0), 1'b1, 1'b0);
        drive(1'b1, AW'(32'h31), IW'(32'hB1), 1'b1, 1'b0);
        drain();

        // Streaming from empty.
        for (int i = 0; i < 10; i++) drive(1'b1, AW'(i), IW'(32'hC00 + i), 1'b1, 1'b0);
        drain();

        // Wrap-around across index 3 -> 0.
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(32'h1 + i), IW'(32'hD0 + i), 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(32'h20 + i), IW'(32'hE0 + i), 1'b0, 1'b0);
        drain();

        // Flush priority over simultaneous enq/deq.
        for (int i = 0; i < 2; i++) drive(1'b1, AW'(32'h50 + i), IW'(32'hF0 + i), 1'b0, 1'b0);
        drive(1'b1, AW'(32'h52), IW'(32'hF2), 1'b1, 1'b1);
        drive(1'b1, AW'(32'h40), IW'(32'h1234), 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) drive(1'b1, AW'(32'h60 + i), IW'(32'h600 + i), 1'b0, 1'b0);
        mid_reset();
        drive(1'b1, AW'(32'h70), IW'(32'h700), 1'b0, 1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                drive($urandom_range(0, 99) < 70, AW'($urandom), IW'($urandom),
                      $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
            end
        end
        drain();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch buffer directly downstream of the synchronized program counter and instruction memory.
- Captures each fetched (pc, pc_4, instr) triple in a small FIFO and presents it to decode through a valid/ready handshake.
- Back-pressures the PC through `pc_en` when the queue cannot accept.
- On a control-flow redirect, `flush` empties the queue, which discards all wrong-path instructions.

Parameters:
- ADDR_W, default `IM_ADDR_BIT (10): width of the word-addressed instruction address.
- INSTR_W, default 32: instruction word width.
- DEPTH, default 4: number of entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: the fetch side holds a valid instruction this cycle.
- in_pc, input, ADDR_W: address of the fetched instruction.
- in_pc_4, input, ADDR_W: sequential next address (in_pc+1, word-addressed).
- in_instr, input, INSTR_W: fetched instruction word.
- in_ready, input-side output, 1: the queue accepts an entry this cycle.
- pc_en, output, 1: enable for the PC register. Equal to in_ready.
- out_valid, output, 1: the head entry is valid.
- out_pc, output, ADDR_W: pc of the head entry.
- out_pc_4, output, ADDR_W: pc_4 of the head entry.
- out_instr, output, INSTR_W: instruction of the head entry.
- out_ready, input, 1: decode consumes the head this cycle.
- flush, input, 1: redirect. Discards all entries.
- count, output, clog2(DEPTH)+1: current occupancy.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries cleared to 0.
  - out_valid=0; out_pc, out_pc_4, out_instr = 0; in_ready = pc_en = 1.
  - Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Handshake:
  - enq = in_valid & in_ready.
  - deq = out_valid & out_ready.
  - in_ready = (count != DEPTH), purely from registered state. There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
- Latency:
  - An entry enqueued at edge N is visible on the out_* ports after edge N (1 cycle).
  - There is no same-cycle bypass from in_* to out_*.
- Output data:
  - out_* = storage[rd_ptr], driven combinationally from registered state.
  - When out_valid=0, out_* show the stale storage contents. Consumers must ignore them.
- Pointer update:
  - wr_ptr advances by 1 on enq; rd_ptr advances by 1 on deq.
  - Both wrap modulo DEPTH (natural overflow of clog2(DEPTH) bits).
  - count += enq - deq.
- Boundary conditions:
  - Empty with in_valid=1: enqueue only. out_valid rises the next cycle.
  - Full (count=DEPTH): in_ready=0 and pc_en=0, so the PC holds. A deq that same cycle frees a slot, but in_ready rises only next cycle.
  - Simultaneous enq and deq when 0<count<DEPTH: count unchanged, both pointers advance.
  - Wrap-around: an entry written at index DEPTH-1 is followed by index 0, and FIFO order is preserved.
- Flush:
  - flush=1 at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any enq or deq in that cycle is ignored; flush has priority.
  - Storage contents are not cleared.
  - Next cycle: out_valid=0, in_ready=1.
  - The redirect target is loaded by the PC, independently of this block, in the same cycle.
- Invariant: 0 <= count <= DEPTH. The assertion (count==DEPTH) -> !enq holds by construction.

Decomposition:
- Shared header (Core.vh) holds `IM_ADDR_BIT and the instruction width.
- A generic sub-module, sync_fifo_core, is natural for the storage array plus pointers and count, with push/pop/clear. fetch_queue packs {pc, pc_4, instr} into one entry and derives pc_en from it.

Test Plan:
- Reset: assert rst mid-run with count=3 -> immediately count=0, out_valid=0, pc_en=1, out_instr=0.
- Fill: out_ready=0; enqueue pc=0x10..0x13 with instr=0xA0..0xA3 -> after the 4th edge count=4, in_ready=0, pc_en=0, out_pc=0x10. A 5th in_valid is not accepted.
- Stream: in_valid=1 and out_ready=1 continuously from empty with pc=0..9 -> count stays 1 after the first edge; decode sees pc 0..9 in order, each with pc_4=pc+1.
- Wrap: enqueue 3, dequeue 3, then enqueue 0x20..0x23 -> read order 0x20..0x23, correct across the index 3 -> 0 wrap.
- Flush priority: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0. Subsequent enq of pc=0x40 appears at the head with out_pc=0x40.
- Full plus deq: count=4, out_ready=1, in_valid=1 -> after the edge count=3 and the incoming entry is not accepted; in_ready=1 the following cycle.
